lcd_bus_receiver: RTL

//  Display-side end of the 8080-style parallel LCD bus (wr/dcx/D[7:0]/sync) driven by the image generator.

---
 rtl/lcd_bus_receiver.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_receiver.sv
// ============================================================================
// Module   : lcd_bus_receiver
// Brief    : 8080-style LCD bus decoder (CASET/PASET/RAMWR/SWRESET/DISPON/
//            DISPOFF) producing windowed RGB565 pixels on a valid/ready port.
//            Define LCD_RX_ERR_CNT_EN to add the err_cnt error counter output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_bus_receiver #(
    parameter int WIDTH   = 240,
    parameter int HEIGHT  = 320,
    parameter int COORD_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sync,
    input  logic               wr,
    input  logic               dcx,
    input  logic [7:0]         D,
    input  logic               px_ready,
    output logic               px_valid,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic [15:0]        px_color,
    output logic               disp_on,
    output logic               overrun
`ifdef LCD_RX_ERR_CNT_EN
    ,
    output logic [7:0]         err_cnt
`endif
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_CASET    = 3'd1;
    localparam logic [2:0] c_ST_PASET    = 3'd2;
    localparam logic [2:0] c_ST_RAMWR_HI = 3'd3;
    localparam logic [2:0] c_ST_RAMWR_LO = 3'd4;
    localparam logic [2:0] c_ST_IGNORE   = 3'd5;

    localparam logic [7:0] c_OP_SWRESET = 8'h01;
    localparam logic [7:0] c_OP_DISPOFF = 8'h28;
    localparam logic [7:0] c_OP_DISPON  = 8'h29;
    localparam logic [7:0] c_OP_CASET   = 8'h2A;
    localparam logic [7:0] c_OP_PASET   = 8'h2B;
    localparam logic [7:0] c_OP_RAMWR   = 8'h2C;

    localparam logic [COORD_W-1:0] c_EC_RST = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] c_EP_RST = COORD_W'(HEIGHT - 1);

    logic [2:0]         state_q, state_d;
    logic               wr_d_q;
    logic [1:0]         arg_cnt_q, arg_cnt_d;
    logic [23:0]        args_q, args_d;
    logic [7:0]         hi_q, hi_d;
    logic [COORD_W-1:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic               px_valid_q, px_valid_d;
    logic [COORD_W-1:0] px_x_q, px_x_d, px_y_q, px_y_d;
    logic [15:0]        px_color_q, px_color_d;
    logic               disp_on_q, disp_on_d;
    logic               overrun_q, overrun_d;
`ifdef LCD_RX_ERR_CNT_EN
    logic [7:0]         err_cnt_q, err_cnt_d;
`endif

    logic               w_acc;
    logic [COORD_W-1:0] w_arg_start, w_arg_end;

    assign w_acc       = wr & ~wr_d_q;
    // Window arguments are 16-bit big-endian; only the low COORD_W bits are kept.
    assign w_arg_start = COORD_W'(args_q[23:8]);
    assign w_arg_end   = COORD_W'({args_q[7:0], D});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_ST_IDLE;
            wr_d_q     <= 1'b0;
            arg_cnt_q  <= '0;
            args_q     <= '0;
            hi_q       <= '0;
            sc_q       <= '0;
            ec_q       <= c_EC_RST;
            sp_q       <= '0;
            ep_q       <= c_EP_RST;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            px_valid_q <= 1'b0;
            px_x_q     <= '0;
            px_y_q     <= '0;
            px_color_q <= '0;
            disp_on_q  <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef LCD_RX_ERR_CNT_EN
            err_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_d_q     <= wr;
            arg_cnt_q  <= arg_cnt_d;
            args_q     <= args_d;
            hi_q       <= hi_d;
            sc_q       <= sc_d;
            ec_q       <= ec_d;
            sp_q       <= sp_d;
            ep_q       <= ep_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            px_valid_q <= px_valid_d;
            px_x_q     <= px_x_d;
            px_y_q     <= px_y_d;
            px_color_q <= px_color_d;
            disp_on_q  <= disp_on_d;
            overrun_q  <= overrun_d;
`ifdef LCD_RX_ERR_CNT_EN
            err_cnt_q  <= err_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        arg_cnt_d  = arg_cnt_q;
        args_d     = args_q;
        hi_d       = hi_q;
        sc_d       = sc_q;
        ec_d       = ec_q;
        sp_d       = sp_q;
        ep_d       = ep_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        px_valid_d = px_valid_q;
        px_x_d     = px_x_q;
        px_y_d     = px_y_q;
        px_color_d = px_color_q;
        disp_on_d  = disp_on_q;
        overrun_d  = overrun_q;
`ifdef LCD_RX_ERR_CNT_EN
        err_cnt_d  = err_cnt_q;
`endif

        if (px_valid_q && px_ready) begin
            px_valid_d = 1'b0;
        end

        if (sync) begin
            state_d   = c_ST_IDLE;
            arg_cnt_d = '0;
        end else if (w_acc && !dcx) begin
            state_d   = c_ST_IDLE;
            arg_cnt_d = '0;
            case (D)
                c_OP_CASET:   state_d = c_ST_CASET;
                c_OP_PASET:   state_d = c_ST_PASET;
                c_OP_RAMWR: begin
                    state_d = c_ST_RAMWR_HI;
                    cur_x_d = sc_q;
                    cur_y_d = sp_q;
                end
                c_OP_DISPON:  disp_on_d = 1'b1;
                c_OP_DISPOFF: disp_on_d = 1'b0;
                c_OP_SWRESET: begin
                    sc_d      = '0;
                    ec_d      = c_EC_RST;
                    sp_d      = '0;
                    ep_d      = c_EP_RST;
                    cur_x_d   = '0;
                    cur_y_d   = '0;
                    disp_on_d = 1'b0;
                    overrun_d = 1'b0;
`ifdef LCD_RX_ERR_CNT_EN
                    err_cnt_d = '0;
`endif
                    // A pending pixel survives a software reset.
                    if (!px_valid_q) begin
                        px_x_d     = '0;
                        px_y_d     = '0;
                        px_color_d = '0;
                    end
                end
                default: begin
                    state_d = c_ST_IGNORE;
`ifdef LCD_RX_ERR_CNT_EN
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
`endif
                end
            endcase
        end else if (w_acc) begin
            case (state_q)
                c_ST_CASET, c_ST_PASET: begin
                    if (arg_cnt_q == 2'd3) begin
                        if (state_q == c_ST_CASET) begin
                            sc_d = w_arg_start;
                            ec_d = w_arg_end;
                        end else begin
                            sp_d = w_arg_start;
                            ep_d = w_arg_end;
                        end
                        state_d   = c_ST_IDLE;
                        arg_cnt_d = '0;
                    end else begin
                        args_d    = {args_q[15:0], D};
                        arg_cnt_d = arg_cnt_q + 2'd1;
                    end
                end
                c_ST_RAMWR_HI: begin
                    hi_d    = D;
                    state_d = c_ST_RAMWR_LO;
                end
                c_ST_RAMWR_LO: begin
                    state_d = c_ST_RAMWR_HI;
                    if (!px_valid_q || px_ready) begin
                        px_valid_d = 1'b1;
                        px_x_d     = cur_x_q;
                        px_y_d     = cur_y_q;
                        px_color_d = {hi_q, D};
                    end else begin
                        overrun_d = 1'b1;
`ifdef LCD_RX_ERR_CNT_EN
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
`endif
                    end
                    // >= makes an inverted window pin the cursor to its start.
                    if (cur_x_q >= ec_q) begin
                        cur_x_d = sc_q;
                        cur_y_d = (cur_y_q >= ep_q) ? sp_q : cur_y_q + 1'b1;
                    end else begin
                        cur_x_d = cur_x_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        px_valid = px_valid_q;
        px_x     = px_x_q;
        px_y     = px_y_q;
        px_color = px_color_q;
        disp_on  = disp_on_q;
        overrun  = overrun_q;
`ifdef LCD_RX_ERR_CNT_EN
        err_cnt  = err_cnt_q;
`endif
    end

endmodule

`default_nettype wire
